prio_grant_arbiter: RTL and testbench

- Sequential arbiter sharing one downstream resource among three requesters A, B, C.
- Fixed priority B > A > C. One-hot grant encoding is {grant_z, grant_y, grant_x}: grant_z serves B, grant_y serves C, grant_x serves A.
- Adds grant hold, a hold-time limit with forced release, and a one-cycle handover gap.
- Sits between the requester logic and the shared output stage.

---
 rtl/prio_grant_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_prio_grant_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/prio_grant_arbiter.sv
// Fixed-priority (B > A > C) grant arbiter with grant hold, forced release after MAX_HOLD cycles and a one-cycle handover gap.
// Optional starvation guard for A and C: define PRIO_ARB_STARVE_GUARD_EN.
module prio_grant_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic req_c,
  output logic grant_x,
  output logic grant_y,
  output logic grant_z,
  output logic busy,
  output logic timeout
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] MAX_CNT = HCW'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state_r;
  logic [HCW-1:0] hold_cnt_r;
  logic [2:0]     mask_r;      // bit order {b, a, c}
  logic           grant_x_r;
  logic           grant_y_r;
  logic           grant_z_r;
  logic           busy_r;
  logic           timeout_r;

  logic [2:0] raw_s;
  logic [2:0] eff_s;
  logic [2:0] pick_s;
  logic [2:0] prio_s;
  logic [2:0] win_s;
  logic [2:0] own_bits_s;
  logic       owner_req_s;

  assign raw_s       = {req_b, req_a, req_c};
  assign eff_s       = raw_s & ~mask_r;
  // A masked sole requester is still served, so the mask only reorders, never starves.
  assign pick_s      = (eff_s != 3'b000) ? eff_s : raw_s;
  assign own_bits_s  = {grant_z_r, grant_x_r, grant_y_r};
  assign owner_req_s = (grant_x_r & req_a) | (grant_y_r & req_c) | (grant_z_r & req_b);

  // Fixed-priority pick among candidate requests.
  always_comb begin
    prio_s = 3'b000;
    if (pick_s[2]) begin
      prio_s = 3'b100;
    end else if (pick_s[1]) begin
      prio_s = 3'b010;
    end else if (pick_s[0]) begin
      prio_s = 3'b001;
    end else begin
      prio_s = 3'b000;
    end
  end

`ifdef PRIO_ARB_STARVE_GUARD_EN
  logic [3:0] age_a_r;
  logic [3:0] age_c_r;

  // Aged requesters override priority and mask; A wins a tie.
  always_comb begin
    win_s = prio_s;
    if ((age_a_r >= 4'd3) && req_a) begin
      win_s = 3'b010;
    end else if ((age_c_r >= 4'd3) && req_c) begin
      win_s = 3'b001;
    end else begin
      win_s = prio_s;
    end
  end

  // Age counters advance on each lost IDLE arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_a_r <= 4'd0;
      age_c_r <= 4'd0;
    end else if (state_r == IDLE) begin
      if (!req_a || win_s[1]) begin
        age_a_r <= 4'd0;
      end else if (age_a_r != 4'd15) begin
        age_a_r <= age_a_r + 4'd1;
      end else begin
        age_a_r <= age_a_r;
      end
      if (!req_c || win_s[0]) begin
        age_c_r <= 4'd0;
      end else if (age_c_r != 4'd15) begin
        age_c_r <= age_c_r + 4'd1;
      end else begin
        age_c_r <= age_c_r;
      end
    end else begin
      age_a_r <= age_a_r;
      age_c_r <= age_c_r;
    end
  end
`else
  assign win_s = prio_s;
`endif

  // Arbitration state machine with registered grant, busy and timeout outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      hold_cnt_r <= '0;
      mask_r     <= 3'b000;
      grant_x_r  <= 1'b0;
      grant_y_r  <= 1'b0;
      grant_z_r  <= 1'b0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mask_r    <= 3'b000;
          timeout_r <= 1'b0;
          if (win_s != 3'b000) begin
            grant_z_r  <= win_s[2];
            grant_x_r  <= win_s[1];
            grant_y_r  <= win_s[0];
            hold_cnt_r <= HCW'(1);
            busy_r     <= 1'b1;
            state_r    <= GRANT;
          end else begin
            grant_z_r  <= 1'b0;
            grant_x_r  <= 1'b0;
            grant_y_r  <= 1'b0;
            hold_cnt_r <= '0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req_s) begin
            grant_x_r  <= 1'b0;
            grant_y_r  <= 1'b0;
            grant_z_r  <= 1'b0;
            hold_cnt_r <= '0;
            mask_r     <= 3'b000;
            timeout_r  <= 1'b0;
            state_r    <= GAP;
          end else if (hold_cnt_r >= MAX_CNT) begin
            grant_x_r  <= 1'b0;
            grant_y_r  <= 1'b0;
            grant_z_r  <= 1'b0;
            hold_cnt_r <= '0;
            mask_r     <= own_bits_s;
            timeout_r  <= 1'b1;
            state_r    <= GAP;
          end else begin
            hold_cnt_r <= hold_cnt_r + HCW'(1);
            timeout_r  <= 1'b0;
            state_r    <= GRANT;
          end
        end
        GAP: begin
          grant_x_r <= 1'b0;
          grant_y_r <= 1'b0;
          grant_z_r <= 1'b0;
          busy_r    <= 1'b0;
          timeout_r <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          hold_cnt_r <= '0;
          mask_r     <= 3'b000;
          grant_x_r  <= 1'b0;
          grant_y_r  <= 1'b0;
          grant_z_r  <= 1'b0;
          busy_r     <= 1'b0;
          timeout_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_x = grant_x_r;
  assign grant_y = grant_y_r;
  assign grant_z = grant_z_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_prio_grant_arbiter.sv
// Scoreboard bench for prio_grant_arbiter: expected {grant_z, grant_y, grant_x, busy, timeout} queued per driven cycle.
module tb_prio_grant_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req_a;
  logic req_b;
  logic req_c;
  logic grant_x;
  logic grant_y;
  logic grant_z;
  logic busy;
  logic timeout;

  int checks_s = 0;
  int errors_s = 0;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  localparam logic [4:0] IDL = 5'b000_0_0;
  localparam logic [4:0] GA  = 5'b001_1_0;
  localparam logic [4:0] GC  = 5'b010_1_0;
  localparam logic [4:0] GB  = 5'b100_1_0;
  localparam logic [4:0] GP  = 5'b000_1_0;
  localparam logic [4:0] TO  = 5'b000_1_1;

  prio_grant_arbiter #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .req_c   (req_c),
    .grant_x (grant_x),
    .grant_y (grant_y),
    .grant_z (grant_z),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks_s++;
    if (got !== exp) begin
      errors_s++;
      $display("FAIL %s: got zyx/busy/to=%b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic a, input logic b,
                      input logic c, input logic [4:0] exp);
    sb_entry_t e;
    rst   = r;
    req_a = a;
    req_b = b;
    req_c = c;
    sb_q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq(e.tag, {grant_z, grant_y, grant_x, busy, timeout}, e.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    req_c = 1'b0;
    @(posedge clk);
    #1;

    step("reset",      1'b1, 1'b0, 1'b0, 1'b0, IDL);
    step("idle",       1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // Reset mid-grant
    step("rg_grant",   1'b0, 1'b1, 1'b0, 1'b0, GA);
    step("rg_hold",    1'b0, 1'b1, 1'b0, 1'b0, GA);
    step("rg_rst",     1'b1, 1'b1, 1'b0, 1'b0, IDL);
    step("rg_regrant", 1'b0, 1'b1, 1'b0, 1'b0, GA);
    step("rg_rel",     1'b0, 1'b0, 1'b0, 1'b0, GP);
    step("rg_idle",    1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // Priority order B > A > C
    step("pr_b",       1'b0, 1'b1, 1'b1, 1'b1, GB);
    step("pr_b_hold",  1'b0, 1'b1, 1'b1, 1'b1, GB);
    step("pr_b_gap",   1'b0, 1'b1, 1'b0, 1'b1, GP);
    step("pr_idle1",   1'b0, 1'b1, 1'b0, 1'b1, IDL);
    step("pr_a",       1'b0, 1'b1, 1'b0, 1'b1, GA);
    step("pr_a_gap",   1'b0, 1'b0, 1'b0, 1'b1, GP);
    step("pr_idle2",   1'b0, 1'b0, 1'b0, 1'b1, IDL);
    step("pr_c",       1'b0, 1'b0, 1'b0, 1'b1, GC);
    step("pr_c_gap",   1'b0, 1'b0, 1'b0, 1'b0, GP);
    step("pr_idle3",   1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // No preemption by a higher-priority request
    step("np_a",       1'b0, 1'b1, 1'b0, 1'b0, GA);
    step("np_a_b1",    1'b0, 1'b1, 1'b1, 1'b0, GA);
    step("np_a_b2",    1'b0, 1'b1, 1'b1, 1'b0, GA);
    step("np_gap",     1'b0, 1'b0, 1'b1, 1'b0, GP);
    step("np_idle",    1'b0, 1'b0, 1'b1, 1'b0, IDL);
    step("np_b",       1'b0, 1'b0, 1'b1, 1'b0, GB);
    step("np_b_gap",   1'b0, 1'b0, 1'b0, 1'b0, GP);
    step("np_idle2",   1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // Timeout with A and C held: 8 grant cycles, pulse, gap, then C
    step("to_a",       1'b0, 1'b1, 1'b0, 1'b1, GA);
    for (int i = 0; i < 7; i++) step("to_a_hold", 1'b0, 1'b1, 1'b0, 1'b1, GA);
    step("to_pulse",   1'b0, 1'b1, 1'b0, 1'b1, TO);
    step("to_idle",    1'b0, 1'b1, 1'b0, 1'b1, IDL);
    step("to_mask_c",  1'b0, 1'b1, 1'b0, 1'b1, GC);
    step("to_c_gap",   1'b0, 1'b0, 1'b0, 1'b0, GP);
    step("to_idle2",   1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // Timeout of a sole requester: it is re-granted despite the mask
    step("so_a",       1'b0, 1'b1, 1'b0, 1'b0, GA);
    for (int i = 0; i < 7; i++) step("so_a_hold", 1'b0, 1'b1, 1'b0, 1'b0, GA);
    step("so_pulse",   1'b0, 1'b1, 1'b0, 1'b0, TO);
    step("so_idle",    1'b0, 1'b1, 1'b0, 1'b0, IDL);
    step("so_regrant", 1'b0, 1'b1, 1'b0, 1'b0, GA);
    step("so_gap",     1'b0, 1'b0, 1'b0, 1'b0, GP);
    step("so_idle2",   1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // Release in the same cycle the counter hits MAX_HOLD: no timeout, no mask
    step("sc_a",       1'b0, 1'b1, 1'b0, 1'b0, GA);
    for (int i = 0; i < 7; i++) step("sc_a_hold", 1'b0, 1'b1, 1'b0, 1'b0, GA);
    step("sc_release", 1'b0, 1'b0, 1'b0, 1'b0, GP);
    step("sc_idle",    1'b0, 1'b1, 1'b0, 1'b1, IDL);
    step("sc_a_wins",  1'b0, 1'b1, 1'b0, 1'b1, GA);
    step("sc_gap",     1'b0, 1'b0, 1'b0, 1'b0, GP);
    step("sc_idle2",   1'b0, 1'b0, 1'b0, 1'b0, IDL);
    step("sc_idle3",   1'b0, 1'b0, 1'b0, 1'b0, IDL);

    // C held while B keeps re-requesting
    step("sg_b1",      1'b0, 1'b0, 1'b1, 1'b1, GB);
    step("sg_gap1",    1'b0, 1'b0, 1'b0, 1'b1, GP);
    step("sg_idle1",   1'b0, 1'b0, 1'b1, 1'b1, IDL);
    step("sg_b2",      1'b0, 1'b0, 1'b1, 1'b1, GB);
    step("sg_gap2",    1'b0, 1'b0, 1'b0, 1'b1, GP);
    step("sg_idle2",   1'b0, 1'b0, 1'b1, 1'b1, IDL);
    step("sg_b3",      1'b0, 1'b0, 1'b1, 1'b1, GB);
    step("sg_gap3",    1'b0, 1'b0, 1'b0, 1'b1, GP);
    step("sg_idle3",   1'b0, 1'b0, 1'b1, 1'b1, IDL);
`ifdef PRIO_ARB_STARVE_GUARD_EN
    step("sg_c_aged",  1'b0, 1'b0, 1'b1, 1'b1, GC);
`else
    step("sg_b4",      1'b0, 1'b0, 1'b1, 1'b1, GB);
`endif
    step("sg_gap4",    1'b0, 1'b0, 1'b0, 1'b0, GP);
    step("sg_idle4",   1'b0, 1'b0, 1'b0, 1'b0, IDL);

    $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
    $finish;
  end

endmodule
